// File: rtl/sha256_pipe_core.sv
// sha256_pipe_core: SHA-256 block compression with 1/2/4 rounds per clock and optional digest chaining
module sha256_pipe_core #(
  parameter int UNROLL = 1,
  parameter bit CHAIN_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic [511:0] in_data,
  input  logic [255:0] iv_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest
);
  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
    $error("UNROLL must be 1, 2 or 4");
  end
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, HOLD} state_t;
  state_t state_q, state_d;
  logic [5:0] t_q;
  logic [15:0][31:0] w_q;
  logic [7:0][31:0] st_q;
  logic [255:0] chain_q, digest_q, src;
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [15:0][31:0] w_next(input logic [15:0][31:0] w);
    logic [15+UNROLL:0][31:0] e;
    e[15:0] = w;
    for (int i = 0; i < UNROLL; i++)
      e[16+i] = (ror(e[14+i], 17) ^ ror(e[14+i], 19) ^ (e[14+i] >> 10)) + e[9+i]
              + (ror(e[1+i], 7) ^ ror(e[1+i], 18) ^ (e[1+i] >> 3)) + e[i];
    return e[15+UNROLL:UNROLL];
  endfunction
  function automatic logic [7:0][31:0] rounds(input logic [7:0][31:0] s, input logic [15:0][31:0] w, input logic [5:0] t);
    logic [31:0] t1, t2;
    for (int i = 0; i < UNROLL; i++) begin
      t1 = s[7] + (ror(s[4], 6) ^ ror(s[4], 11) ^ ror(s[4], 25)) + ((s[4] & s[5]) ^ (~s[4] & s[6]))
         + K[t + 6'(i)] + w[i];
      t2 = (ror(s[0], 2) ^ ror(s[0], 13) ^ ror(s[0], 22)) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      s = {s[6:4], s[3] + t1, s[2:0], t1 + t2};
    end
    return s;
  endfunction
  assign src = (!CHAIN_EN || in_first) ? iv_in : digest_q;
  assign digest = digest_q;
  // next state and handshake outputs
  always_comb begin
    in_ready = state_q == IDLE;
    out_valid = state_q == HOLD;
    state_d = state_q == IDLE ? (in_valid ? ROUND : IDLE) :
              state_q == ROUND ? (t_q == 6'(64 - UNROLL) ? FINAL : ROUND) :
              state_q == FINAL ? HOLD : (out_ready ? IDLE : HOLD);
  end
  // state register, message window, working variables and digest
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q <= '0;
      w_q <= '0;
      st_q <= '0;
      chain_q <= '0;
      digest_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        t_q <= '0;
        chain_q <= src;
        for (int i = 0; i < 16; i++) w_q[i] <= in_data[511-32*i -: 32];
        for (int i = 0; i < 8; i++) st_q[i] <= src[255-32*i -: 32];
      end
      if (state_q == ROUND) begin
        st_q <= rounds(st_q, w_q, t_q);
        w_q <= w_next(w_q);
        t_q <= t_q + 6'(UNROLL);
      end
      if (state_q == FINAL)
        for (int i = 0; i < 8; i++) digest_q[255-32*i -: 32] <= chain_q[255-32*i -: 32] + st_q[i];
    end
  end
endmodule

// File: tb/tb_sha256_pipe_core.sv
// tb_sha256_pipe_core: directed known-answer checks of sha256_pipe_core across unroll and chaining options
module tb_sha256_pipe_core;
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_D = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_D = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] ABC_B = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B2 = {480'h0, 32'h000001c0};
  logic clk = 0, rst = 1, in_valid = 0, in_first = 0, out_ready = 0;
  logic [511:0] in_data = '0;
  logic [255:0] iv_in = '0;
  logic in_ready [4];
  logic out_valid [4];
  logic [255:0] digest [4];
  int tests = 0, fails = 0;
  int lat [4];
  always #5 clk = ~clk;
  sha256_pipe_core #(.UNROLL(1), .CHAIN_EN(1)) u_u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_first(in_first), .in_data(in_data), .iv_in(iv_in), .out_valid(out_valid[0]), .out_ready(out_ready), .digest(digest[0]));
  sha256_pipe_core #(.UNROLL(2), .CHAIN_EN(1)) u_u2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_first(in_first), .in_data(in_data), .iv_in(iv_in), .out_valid(out_valid[1]), .out_ready(out_ready), .digest(digest[1]));
  sha256_pipe_core #(.UNROLL(4), .CHAIN_EN(1)) u_u4 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_first(in_first), .in_data(in_data), .iv_in(iv_in), .out_valid(out_valid[2]), .out_ready(out_ready), .digest(digest[2]));
  sha256_pipe_core #(.UNROLL(4), .CHAIN_EN(0)) u_nc (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[3]),
    .in_first(in_first), .in_data(in_data), .iv_in(iv_in), .out_valid(out_valid[3]), .out_ready(out_ready), .digest(digest[3]));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic scramble();
    for (int i = 0; i < 16; i++) in_data[32*i +: 32] = $urandom();
    for (int i = 0; i < 8; i++) iv_in[32*i +: 32] = $urandom();
    in_first = 1'($urandom_range(0, 1));
  endtask
  task automatic send(input logic [511:0] d, input logic [255:0] iv, input logic f);
    in_data = d;
    iv_in = iv;
    in_first = f;
    in_valid = 1;
    tick();
    in_valid = 0;
  endtask
  task automatic wait_done();
    lat = '{-1, -1, -1, -1};
    for (int c = 1; c <= 100; c++) begin
      for (int k = 0; k < 4; k++) if (out_valid[k] && lat[k] < 0) lat[k] = c;
      if (lat[0] > 0 && lat[1] > 0 && lat[2] > 0 && lat[3] > 0) break;
      scramble();
      tick();
    end
  endtask
  task automatic release_all();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask
  initial begin
    logic [255:0] d0;
    int bad, seen;
    tick();
    tick();
    check("rst_in_ready", 256'(in_ready[0]), 256'd1);
    check("rst_out_valid", 256'(out_valid[0]), 256'd0);
    check("rst_digest", digest[0], 256'd0);
    rst = 0;
    tick();
    send(ABC_B, IV, 1);
    wait_done();
    check("abc_lat_u1", 256'(lat[0]), 256'd66);
    check("abc_lat_u2", 256'(lat[1]), 256'd34);
    check("abc_lat_u4", 256'(lat[2]), 256'd18);
    check("abc_dig_u1", digest[0], ABC_D);
    check("abc_dig_u2", digest[1], ABC_D);
    check("abc_dig_u4", digest[2], ABC_D);
    d0 = digest[0];
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      scramble();
      tick();
      if (!out_valid[0] || digest[0] !== d0 || in_ready[0]) bad++;
    end
    in_valid = 0;
    check("hold_stable", 256'(bad), 256'd0);
    release_all();
    check("rel_in_ready", 256'(in_ready[0]), 256'd1);
    check("rel_out_valid", 256'(out_valid[0]), 256'd0);
    check("rel_digest_kept", digest[0], ABC_D);
    send(B1, IV, 1);
    wait_done();
    release_all();
    send(B2, {8{32'hdeadbeef}}, 0);
    wait_done();
    check("two_dig_u1", digest[0], TWO_D);
    check("two_dig_u2", digest[1], TWO_D);
    check("two_dig_u4", digest[2], TWO_D);
    release_all();
    send(ABC_B, IV, 0);
    wait_done();
    check("nochain_lat", 256'(lat[3]), 256'd18);
    check("nochain_dig", digest[3], ABC_D);
    release_all();
    send(ABC_B, IV, 1);
    for (int i = 0; i < 30; i++) tick();
    rst = 1;
    tick();
    rst = 0;
    check("abort_in_ready", 256'(in_ready[0]), 256'd1);
    check("abort_out_valid", 256'(out_valid[0]), 256'd0);
    check("abort_digest", digest[0], 256'd0);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (out_valid[0]) seen++;
      tick();
    end
    check("abort_no_valid", 256'(seen), 256'd0);
    send(ABC_B, IV, 1);
    wait_done();
    check("after_abort_lat", 256'(lat[0]), 256'd66);
    check("after_abort_dig", digest[0], ABC_D);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sha256_pipe_core.md
SHA256_PIPE_CORE -- requirements
Module: sha256_pipe_core

Interface
REQ-001 SHALL provide parameter UNROLL, default 1: compression rounds evaluated per clock; legal values 1, 2, 4; any other value SHALL fail elaboration.
REQ-002 SHALL provide parameter CHAIN_EN, default 1: 1 = in_first selects chaining source; 0 = every block uses iv_in.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 in_valid  input  1  block offered.
REQ-006 in_ready  output  1  core can accept a block.
REQ-007 in_first  input  1  1 = chaining value is iv_in; 0 = chaining value is stored digest.
REQ-008 in_data  input  512  padded message block; W0 = in_data[511:480], W15 = in_data[31:0].
REQ-009 iv_in  input  256  initial chaining value; H0 = iv_in[255:224], H7 = iv_in[31:0].
REQ-010 out_valid  output  1  digest available.
REQ-011 out_ready  input  1  consumer accepts digest.
REQ-012 digest  output  256  chaining value after the last block; H0 in [255:224].

Function
REQ-013 SHALL implement the FSM states IDLE, ROUND, FINAL and HOLD.
REQ-014 IDLE: in_ready=1; on in_valid=1 (accept edge) latch in_data into a 16-word rolling W window, load a..h and the chaining register from the selected source (REQ-007), clear the round counter, and go to ROUND.
REQ-015 ROUND: each cycle SHALL apply UNROLL consecutive rounds t..t+UNROLL-1 using K[t] and W[t]; the counter SHALL advance by UNROLL; when the last group ending at round 63 completes, the FSM SHALL go to FINAL.
REQ-016 W[t] for t>=16 SHALL be computed in-window as sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16]; storage SHALL be exactly 16 words, with the window shifting UNROLL words per cycle.
REQ-017 FINAL: digest register SHALL become the word-wise sum of the chaining register and a..h, mod 2^32 per word with no carry between words; the FSM SHALL then go to HOLD.
REQ-018 HOLD: out_valid=1 and digest stable; on out_ready=1 the FSM SHALL return to IDLE; otherwise it SHALL stay in HOLD indefinitely.
REQ-019 Latency SHALL be exactly 64/UNROLL + 2 cycles from the accept edge to the first cycle with out_valid=1; throughput SHALL be one block per 64/UNROLL + 3 cycles when out_ready is held at 1.
REQ-020 in_ready SHALL be 0 outside IDLE; in_valid in other states SHALL be ignored, with no latching and no effect.
REQ-021 The digest register SHALL persist after the output handshake and serve as the chaining value for a subsequent in_first=0 block.
REQ-022 in_first=0 with no prior digest since reset SHALL chain from the all-zero digest register.
REQ-023 With CHAIN_EN=0, in_first SHALL be ignored and iv_in always used.
REQ-024 in_data, iv_in and in_first SHALL be sampled only on the accept edge; later changes SHALL have no effect.
REQ-025 All additions SHALL be modulo 2^32; the K constants SHALL be the 64 FIPS 180-4 values held internally.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE, round counter 0, digest 0, a..h 0 and W window 0, overriding every other input in that cycle.
REQ-027 After reset: in_ready=1, out_valid=0, digest=0 from the first cycle after the reset edge.
REQ-028 Reset asserted during ROUND, FINAL or HOLD SHALL abort the block; no out_valid pulse SHALL follow.

Verification
REQ-029 UNROLL=1, in_first=1, iv_in=6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19, in_data=61626380 followed by 14 zero words then 00000018 -> out_valid at accept+66 cycles, digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-030 Same stimulus with UNROLL=2 and UNROLL=4 -> identical digest at accept+34 and accept+18 cycles respectively.
REQ-031 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 with in_first=1 and standard IV, block 2 with in_first=0 -> digest=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-032 out_ready held 0 for 20 cycles in HOLD -> out_valid stays 1, digest stable, in_ready stays 0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-033 rst=1 at round 30 -> next cycle in_ready=1, out_valid=0, digest=0; a following "abc" block yields the REQ-029 digest.
REQ-034 in_data changed every cycle after the accept edge -> digest equals that of the accepted block.
